// File: rtl/cluster_neighbor_scanner_pkg.sv
// cns_pkg: scanner states, no-hop sentinel, address stride and fixed-point multiply.
package cns_pkg;
  typedef enum logic [3:0] {
    IDLE, CLUS, BATT, QVAL, LIST, HCM, NBRID, SINK, NEXT, BESTID, WRCNT, DONE
  } state_t;
  localparam int STRIDE = 2;
  function automatic int no_hop(input int num_neighbors);
    return num_neighbors + 1;
  endfunction
  function automatic logic [31:0] fx_mul_sat(input logic [31:0] a, input logic [31:0] b,
                                             input int frac, input int width);
    logic [63:0] p;
    logic [63:0] lim;
    p = ({32'd0, a} * {32'd0, b}) >> frac;
    lim = (64'd1 << width) - 64'd1;
    return p > lim ? lim[31:0] : p[31:0];
  endfunction
endpackage

// File: rtl/cluster_neighbor_scanner_if.sv
// cluster_neighbor_scanner_if: control, memory and result signals of the neighbour scanner.
interface cluster_neighbor_scanner_if #(parameter int WORD_WIDTH = 16);
  logic start;
  logic [WORD_WIDTH-1:0] my_cluster_id, my_best, battery_threshold;
  logic [WORD_WIDTH-1:0] mem_addr, mem_rdata, mem_wdata;
  logic mem_wr_en, busy, done;
  logic [WORD_WIDTH-1:0] besthop, bestvalue, best_neighbor_id, next_sink, better_count;
  modport master(
    output start, my_cluster_id, my_best, battery_threshold, mem_rdata,
    input mem_addr, mem_wr_en, mem_wdata, busy, done,
    input besthop, bestvalue, best_neighbor_id, next_sink, better_count
  );
  modport slave(
    input start, my_cluster_id, my_best, battery_threshold, mem_rdata,
    output mem_addr, mem_wr_en, mem_wdata, busy, done,
    output besthop, bestvalue, best_neighbor_id, next_sink, better_count
  );
endinterface

// File: rtl/cluster_neighbor_scanner_hcm_weight.sv
// cns_hcm_weight: HCM index from battery level and HCM-weighted Q-value, purely combinational.
module cns_hcm_weight
  import cns_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int HCM_LENGTH = 11
) (
  input  logic [WORD_WIDTH-1:0] battery,
  input  logic [WORD_WIDTH-1:0] q,
  input  logic [WORD_WIDTH-1:0] hcm,
  output logic [WORD_WIDTH-1:0] k,
  output logic [WORD_WIDTH-1:0] w
);
  localparam int DW = 2 * WORD_WIDTH;
  localparam logic [DW-1:0] TOP = DW'(HCM_LENGTH - 1);
  logic [DW-1:0] prod, kr;
  always_comb begin
    prod = TOP * DW'(battery) + DW'((1 << FRAC_BITS) - 1);
    kr = prod >> FRAC_BITS;
    k = kr > TOP ? TOP[WORD_WIDTH-1:0] : kr[WORD_WIDTH-1:0];
    w = WORD_WIDTH'(fx_mul_sat(32'(q), 32'(hcm), FRAC_BITS, WORD_WIDTH));
  end
endmodule

// File: rtl/cluster_neighbor_scanner.sv
// cluster_neighbor_scanner: sequential better-neighbour / best-hop / sink search over a memory table.
// Define CNS_BETTER_LIST_EN to also write each better neighbour index to the better list.
module cluster_neighbor_scanner
  import cns_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int NUM_NEIGHBORS = 64,
  parameter int NUM_SINKS = 16,
  parameter int HCM_LENGTH = 11,
  parameter logic [WORD_WIDTH-1:0] SINK_BASE = 16'h0008,
  parameter logic [WORD_WIDTH-1:0] NBR_ID_BASE = 16'h0048,
  parameter logic [WORD_WIDTH-1:0] CLUSTER_BASE = 16'h00C8,
  parameter logic [WORD_WIDTH-1:0] BATT_BASE = 16'h0148,
  parameter logic [WORD_WIDTH-1:0] QVAL_BASE = 16'h01C8,
  parameter logic [WORD_WIDTH-1:0] HCM_BASE = 16'h0648,
  parameter logic [WORD_WIDTH-1:0] BETTER_BASE = 16'h0668,
  parameter logic [WORD_WIDTH-1:0] COUNT_ADDR = 16'h068C
) (
  input logic clock,
  input logic nrst,
  cluster_neighbor_scanner_if.slave bus
);
  localparam int IW = $clog2(NUM_NEIGHBORS + 2);
  localparam int JW = $clog2(NUM_SINKS + 1);
  localparam logic [WORD_WIDTH-1:0] NO_HOP = WORD_WIDTH'(no_hop(NUM_NEIGHBORS));
`ifdef CNS_BETTER_LIST_EN
  localparam bit LIST_EN = 1'b1;
`else
  localparam bit LIST_EN = 1'b0;
`endif
  state_t state, next_state;
  logic [IW-1:0] i, i_n;
  logic [JW-1:0] j, j_n;
  logic [WORD_WIDTH-1:0] rdata, battery, q, nbr_id, k, w, addr_n, wdata_n;
  logic wr_n, launch;
  function automatic logic [WORD_WIDTH-1:0] at(input logic [WORD_WIDTH-1:0] base,
                                               input logic [WORD_WIDTH-1:0] idx);
    return base + WORD_WIDTH'(STRIDE) * idx;
  endfunction
  assign rdata = bus.mem_rdata;
  assign launch = (state inside {IDLE, DONE}) && bus.start;
  cns_hcm_weight #(.WORD_WIDTH(WORD_WIDTH), .FRAC_BITS(FRAC_BITS), .HCM_LENGTH(HCM_LENGTH)) u_weight (
    .battery(battery), .q(q), .hcm(rdata), .k(k), .w(w)
  );
  always_ff @(posedge clock) state <= !nrst ? IDLE : next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: next_state = bus.start ? CLUS : state;
      CLUS: next_state = rdata == bus.my_cluster_id ? BATT : NEXT;
      BATT: next_state = rdata < bus.battery_threshold ? NEXT : QVAL;
      QVAL: next_state = rdata <= bus.my_best ? (LIST_EN ? LIST : HCM) : NBRID;
      LIST: next_state = HCM;
      HCM: next_state = NBRID;
      NBRID: next_state = SINK;
      SINK: next_state = j == JW'(NUM_SINKS - 1) ? NEXT : SINK;
      NEXT: next_state = i == IW'(NUM_NEIGHBORS - 1) ? BESTID : CLUS;
      BESTID: next_state = WRCNT;
      WRCNT: next_state = DONE;
      default: next_state = IDLE;
    endcase
  end
  // memory controls are registered: each state sees the address chosen on its entry
  always_comb begin
    bus.busy = !(state inside {IDLE, DONE});
    bus.done = state == DONE;
    i_n = launch ? '0 : state == NEXT ? i + 1'b1 : i;
    j_n = state == SINK ? j + 1'b1 : '0;
    wr_n = next_state inside {LIST, WRCNT};
    wdata_n = next_state == LIST ? WORD_WIDTH'(i) : next_state == WRCNT ? bus.better_count : '0;
    case (next_state)
      CLUS: addr_n = at(CLUSTER_BASE, WORD_WIDTH'(i_n));
      BATT: addr_n = at(BATT_BASE, WORD_WIDTH'(i));
      QVAL: addr_n = at(QVAL_BASE, WORD_WIDTH'(i));
      LIST: addr_n = at(BETTER_BASE, bus.better_count);
      HCM: addr_n = at(HCM_BASE, k);
      NBRID: addr_n = at(NBR_ID_BASE, WORD_WIDTH'(i));
      SINK: addr_n = at(SINK_BASE, WORD_WIDTH'(j_n));
      BESTID: addr_n = bus.besthop != NO_HOP ? at(NBR_ID_BASE, bus.besthop) : bus.mem_addr;
      WRCNT: addr_n = COUNT_ADDR;
      default: addr_n = bus.mem_addr;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!nrst) begin
      i <= '0;
      j <= '0;
      battery <= '0;
      q <= '0;
      nbr_id <= '0;
      bus.mem_addr <= CLUSTER_BASE;
      bus.mem_wr_en <= 1'b0;
      bus.mem_wdata <= '0;
    end else begin
      i <= i_n;
      j <= j_n;
      bus.mem_addr <= addr_n;
      bus.mem_wr_en <= wr_n;
      bus.mem_wdata <= wdata_n;
      if (state == BATT) battery <= rdata;
      if (state == QVAL) q <= rdata;
      if (state == NBRID) nbr_id <= rdata;
    end
  end
  always_ff @(posedge clock) begin
    if (!nrst || launch) begin
      bus.besthop <= NO_HOP;
      bus.next_sink <= NO_HOP;
      bus.bestvalue <= '1;
      bus.best_neighbor_id <= '0;
      bus.better_count <= '0;
    end else begin
      if (state == QVAL && rdata <= bus.my_best) bus.better_count <= bus.better_count + 1'b1;
      if (state == HCM && w < bus.bestvalue) begin
        bus.besthop <= WORD_WIDTH'(i);
        bus.bestvalue <= w;
      end
      if (state == SINK && rdata == nbr_id) bus.next_sink <= WORD_WIDTH'(i);
      if (state == BESTID && bus.besthop != NO_HOP) bus.best_neighbor_id <= rdata;
    end
  end
endmodule
